poly_mult_mod: RTL

Parametrised schoolbook polynomial multiplier over Z_Q[x] for the SNTRUP757 core. It reads operands a(x) and b(x) from two coefficient memories and accumulates reduced products into an external accumulator memory. Every coefficient is reduced modulo Q, and the product is optionally folded modulo x^P − x − 1. It is the next generation of the existing FSM/datapath multiplier, adding configurable field and ring size, on-the-fly mod-Q reduction, ring folding, a busy flag and degree validation.

---
 rtl/poly_mult_mod.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/poly_mult_mod.sv
// poly_mult_mod: schoolbook multiplier over Z_Q[x]. It accumulates a(x)*b(x) into an
// external accumulator memory. Every coefficient is reduced mod Q on the fly, and the
// product is optionally folded modulo x^P - x - 1.
//
// Latency (start accepted to done):
//   1 (CHECK) + (D+1) (CLEAR) + 3(dega+1)(degb+1) (MAC) + 8*max(0,D-P+1) (FOLD) + 1 (FIN).
//
// Handshake: start is a one-cycle request. It is ignored unless the FSM is idle, so there
// is no backpressure beyond the busy flag.
//
// Optional feature: define RING_REDUCE_EN to build the FOLD state (ring reduction).
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   start, dega, degb     request and operand degrees (sampled on acceptance)
//   busy, done, err, deg  status; err is sticky until the next accepted start
//   a_addr/a_rdata        operand a memory (1-cycle read latency)
//   b_addr/b_rdata        operand b memory (1-cycle read latency)
//   acc_addr/acc_wdata/acc_we/acc_rdata
//                         single-port accumulator memory (1-cycle read latency)
module poly_mult_mod #(
    parameter int COEF_W = 13,
    parameter int ADDR_W = 11,
    parameter int Q      = 5167,
    parameter int P      = 757
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dega,
    input  logic [ADDR_W-1:0] degb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] deg,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [COEF_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [COEF_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [COEF_W-1:0] acc_wdata,
    output logic              acc_we,
    input  logic [COEF_W-1:0] acc_rdata
);

    localparam logic [COEF_W:0]   Q_W   = (COEF_W+1)'(Q);
    localparam logic [ADDR_W-1:0] P_MAX = ADDR_W'(P - 1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
`ifdef RING_REDUCE_EN
    localparam logic [ADDR_W-1:0] P_W   = ADDR_W'(P);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CLEAR,
        S_MAC,
`ifdef RING_REDUCE_EN
        S_FOLD,
`endif
        S_FIN
    } state_t;

    state_t            state;
    // Sub-step within a MAC term (0=RD, 1=WT, 2=WR) or within a fold step (0..7).
    logic [2:0]        phase;
    logic [ADDR_W-1:0] dega_r;
    logic [ADDR_W-1:0] degb_r;
    logic [ADDR_W-1:0] d_r;
`ifdef RING_REDUCE_EN
    logic [ADDR_W-1:0] k_r;
    logic [COEF_W-1:0] c_r;
    logic [COEF_W-1:0] fold_sum;
`endif
    logic [COEF_W-1:0] mac_sum;

    // Exact x mod Q by restoring shift-subtract, one bit per step.
    // The remainder stays below Q, so 2r+1 < 2Q fits in COEF_W+1 bits.
    function automatic logic [COEF_W-1:0] mod_q(input logic [2*COEF_W-1:0] x);
        logic [COEF_W:0] r;
        r = '0;
        for (int b = 2*COEF_W-1; b >= 0; b--) begin
            r = {r[COEF_W-1:0], x[b]};
            if (r >= Q_W) begin
                r = r - Q_W;
            end
        end
        return r[COEF_W-1:0];
    endfunction

    // Both inputs are already below Q, so a single conditional subtract suffices.
    function automatic logic [COEF_W-1:0] add_mod(input logic [COEF_W-1:0] x,
                                                  input logic [COEF_W-1:0] y);
        logic [COEF_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_W) begin
            s = s - Q_W;
        end
        return s[COEF_W-1:0];
    endfunction

    // Operands may be unreduced, so the full-width product is reduced exactly.
    function automatic logic [COEF_W-1:0] mul_mod(input logic [COEF_W-1:0] x,
                                                  input logic [COEF_W-1:0] y);
        logic [2*COEF_W-1:0] prod;
        prod = {{COEF_W{1'b0}}, x} * {{COEF_W{1'b0}}, y};
        return mod_q(prod);
    endfunction

    // Read data is valid in the WT cycle; the sum is registered straight into acc_wdata.
    assign mac_sum = add_mod(acc_rdata, mul_mod(a_rdata, b_rdata));
`ifdef RING_REDUCE_EN
    assign fold_sum = add_mod(acc_rdata, c_r);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            deg       <= '0;
            a_addr    <= '0;
            b_addr    <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_we    <= 1'b0;
            dega_r    <= '0;
            degb_r    <= '0;
            d_r       <= '0;
`ifdef RING_REDUCE_EN
            k_r       <= '0;
            c_r       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        dega_r <= dega;
                        degb_r <= degb;
                        state  <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (dega_r > P_MAX || degb_r > P_MAX) begin
                        err   <= 1'b1;
                        deg   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end else begin
                        d_r       <= dega_r + degb_r;
                        acc_addr  <= '0;
                        acc_wdata <= '0;
                        acc_we    <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (acc_addr == d_r) begin
                        acc_we   <= 1'b0;
                        a_addr   <= '0;
                        b_addr   <= '0;
                        acc_addr <= '0;
                        phase    <= '0;
                        state    <= S_MAC;
                    end else begin
                        acc_addr <= acc_addr + A_ONE;
                    end
                end

                // acc_addr always tracks a_addr + b_addr (i + j).
                S_MAC: begin
                    case (phase)
                        3'd0: phase <= 3'd1;
                        3'd1: begin
                            acc_wdata <= mac_sum;
                            acc_we    <= 1'b1;
                            phase     <= 3'd2;
                        end
                        default: begin
                            acc_we <= 1'b0;
                            phase  <= 3'd0;
                            if (b_addr == degb_r) begin
                                b_addr <= '0;
                                if (a_addr == dega_r) begin
`ifdef RING_REDUCE_EN
                                    if (d_r >= P_W) begin
                                        k_r      <= d_r;
                                        acc_addr <= d_r;
                                        state    <= S_FOLD;
                                    end else begin
                                        deg   <= d_r;
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                        state <= S_FIN;
                                    end
`else
                                    deg   <= d_r;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_FIN;
`endif
                                end else begin
                                    a_addr   <= a_addr + A_ONE;
                                    acc_addr <= a_addr + A_ONE;
                                end
                            end else begin
                                b_addr   <= b_addr + A_ONE;
                                acc_addr <= acc_addr + A_ONE;
                            end
                        end
                    endcase
                end

`ifdef RING_REDUCE_EN
                // x^k = x^(k-P+1) + x^(k-P). Since k <= 2P-2, both targets are below P,
                // so one pass from the top coefficient down leaves no cascade.
                S_FOLD: begin
                    case (phase)
                        3'd0: phase <= 3'd1;
                        3'd1: begin
                            c_r      <= acc_rdata;
                            acc_addr <= k_r - P_W;
                            phase    <= 3'd2;
                        end
                        3'd2: phase <= 3'd3;
                        3'd3: begin
                            acc_wdata <= fold_sum;
                            acc_we    <= 1'b1;
                            phase     <= 3'd4;
                        end
                        3'd4: begin
                            acc_we   <= 1'b0;
                            acc_addr <= acc_addr + A_ONE;
                            phase    <= 3'd5;
                        end
                        3'd5: phase <= 3'd6;
                        3'd6: begin
                            acc_wdata <= fold_sum;
                            acc_we    <= 1'b1;
                            phase     <= 3'd7;
                        end
                        default: begin
                            acc_we <= 1'b0;
                            phase  <= 3'd0;
                            if (k_r == P_W) begin
                                deg   <= P_MAX;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_FIN;
                            end else begin
                                k_r      <= k_r - A_ONE;
                                acc_addr <= k_r - A_ONE;
                            end
                        end
                    endcase
                end
`endif

                // done is high and busy low here; a start in this cycle is deliberately ignored.
                S_FIN: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
